rvfi_commit_tracker: RTL
========================

# rvfi_commit_tracker

Parametrised retirement tracker between the core's commit lanes and the RVFI monitor/testbench. It generalises the single-lane order counter and self-jump halt check to NUM_PORTS in-order commit lanes. It adds a configurable halt-repeat threshold, a no-commit watchdog and a lane-contiguity error check. It is synthesizable, is driven from the core's writeback stage, and feeds rvfi.order, rvfi.halt and the bench's timeout and error checks.

## Interface
- NUM_PORTS, 2: commit lanes per cycle; lane 0 is oldest; range 1–4.
- XLEN, 32: PC width.
- ORDER_W, 64: order counter width.
- HALT_REPEAT, 2: consecutive committed self-jumps (pc_wdata == pc_rdata) that declare halt; ≥1.
- WDOG_W, 16: watchdog counter width; timeout after 2^WDOG_W−1 commit-free cycles.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- commit_valid  in  NUM_PORTS  lane i retires an instruction this cycle.
- commit_pc_rdata  in  NUM_PORTS×XLEN  PC of lane i's instruction.
- commit_pc_wdata  in  NUM_PORTS×XLEN  next PC of lane i's instruction.
- commit_accept  out  NUM_PORTS  lane i is counted (combinational).
- order  out  NUM_PORTS×ORDER_W  order value of lane i (combinational).
- commit_count  out  ORDER_W  registered running total of accepted commits.
- halt  out  1  sticky; infinite loop detected.
- timeout  out  1  sticky; watchdog expired.
- error  out  1  sticky; non-contiguous commit_valid seen.

## Operation
- States: IDLE (reset, no commit yet), RUN, HALTED, TIMEOUT, ERROR. HALTED, TIMEOUT and ERROR are terminal until rst.
- IDLE→RUN: the first cycle with any accepted lane.
- IDLE/RUN→ERROR: commit_valid is non-contiguous (lane i valid while some lane j<i is invalid). Nothing is accepted that cycle. Error takes priority over halt and timeout.
- Acceptance in IDLE/RUN: lanes are scanned 0→NUM_PORTS−1 with a running repeat count rc. A self-jump lane increments rc; any other valid lane sets rc to 0. The lane where rc reaches HALT_REPEAT is accepted. Younger lanes that cycle are not accepted. Next state is HALTED.
- No lanes are accepted in terminal states.
- order[i] = commit_count + (number of accepted lanes j<i). This value is only meaningful when commit_accept[i] is high; otherwise it is don't-care but still driven.
- commit_count advances by the popcount of commit_accept. It wraps modulo 2^ORDER_W.
- Registered rc persists across cycles and across idle gaps. It resets only on a non-self-jump commit or on rst.
- Watchdog: in IDLE/RUN it clears to 0 on any accepted lane, otherwise it increments. At all-ones it enters TIMEOUT. A commit in the same cycle as the expiry value wins: the counter clears and there is no timeout.
- halt = (state==HALTED), timeout = (state==TIMEOUT), error = (state==ERROR).

## Timing
- Reset values (asynchronous assertion, synchronous-safe release): state=IDLE, commit_count=0, rc=0, watchdog=0. This gives halt=timeout=error=0, commit_accept=0, and order[i]=0 for all i.
- commit_accept and order have zero latency (combinational from the registered state and the current inputs).
- commit_count, halt, timeout and error update on the clock edge ending the triggering cycle, so they are visible one cycle after the commit.
- rst asserted mid-run clears everything immediately. The first commit after release gets order 0.
- There is no backpressure: commit_accept is informational only and the core never stalls on it.

## Structure
- rvfi_commit_tracker_pkg holds:
  - the tracker_state_e enum (IDLE, RUN, HALTED, TIMEOUT, ERROR);
  - the lane_t struct {valid, pc_rdata, pc_wdata};
  - the localparam defaults.
- Sub-module commit_lane_scan is combinational. Inputs: lane_t array, rc, state. Outputs: accept mask, per-lane offsets, next rc, halt_hit, contig_err.
- The top level holds the registers and the next-state logic.

## Test plan
- Sequential commits: NUM_PORTS=2, commit_valid=2'b11 with PCs 0x60/0x64 then 0x64/0x68 for 3 cycles → order pairs (0,1),(2,3),(4,5); commit_count=6 after the last edge; halt=0.
- Same-cycle halt: HALT_REPEAT=2, commit_valid=2'b11 with both lanes pc_rdata=pc_wdata=0x80 → both lanes accepted; halt=1 next cycle; later commits are not accepted and commit_count stays frozen.
- Mid-cycle halt: HALT_REPEAT=1, lane0 a self-jump at 0x90, lane1 valid → commit_accept=2'b01; commit_count +1; halt=1.
- Repeat broken: a self-jump, then a normal commit, then a self-jump (HALT_REPEAT=2, one lane per cycle) → halt stays 0. A further self-jump → halt=1.
- Watchdog: WDOG_W=4, no commits for 15 cycles after reset → timeout=1 on the 15th edge. A variant with a commit on cycle 15 → no timeout; the watchdog restarts.
- Contiguity violation and reset: commit_valid=2'b10 → commit_accept=0, error=1 next cycle. Asserting rst (low) mid-run → all outputs 0 asynchronously; after release, the first commit gets order=0.

Source files
------------

// File: rtl/rvfi_commit_tracker_pkg.sv
// rtl/rvfi_commit_tracker_pkg.sv - shared types and defaults for the commit tracker
package rvfi_commit_tracker_pkg;

    localparam int NUM_PORTS_DEF   = 2;
    localparam int XLEN_DEF        = 32;
    localparam int ORDER_W_DEF     = 64;
    localparam int HALT_REPEAT_DEF = 2;
    localparam int WDOG_W_DEF      = 16;

    // Lane PCs are carried at the widest supported XLEN and zero-extended.
    localparam int PC_MAX_W = 64;
    localparam int OFF_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        HALTED,
        TIMEOUT,
        ERROR
    } tracker_state_e;

    typedef struct packed {
        logic                valid;
        logic [PC_MAX_W-1:0] pc_rdata;
        logic [PC_MAX_W-1:0] pc_wdata;
    } lane_t;

endpackage

// File: rtl/rvfi_commit_tracker_scan.sv
// rtl/rvfi_commit_tracker_scan.sv - combinational per-cycle lane scan (accept mask, offsets, repeat count)
module commit_lane_scan
    import rvfi_commit_tracker_pkg::*;
#(
    parameter int NUM_PORTS   = NUM_PORTS_DEF,
    parameter int HALT_REPEAT = HALT_REPEAT_DEF,
    parameter int RC_W        = 2
) (
    input  lane_t          [NUM_PORTS-1:0]            lanes,
    input  logic           [RC_W-1:0]                 rc,
    input  tracker_state_e                            state,
    output logic           [NUM_PORTS-1:0]            accept,
    output logic           [NUM_PORTS-1:0][OFF_W-1:0] offset,
    output logic           [RC_W-1:0]                 next_rc,
    output logic                                      halt_hit,
    output logic                                      contig_err
);

    logic             gap;
    logic             live;
    logic [OFF_W-1:0] cnt;

    always_comb begin
        gap        = 1'b0;
        contig_err = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!lanes[i].valid) gap = 1'b1;
            else if (gap)        contig_err = 1'b1;
        end
    end

    // Lanes past the one that completes the halt loop are not retired.
    always_comb begin
        accept   = '0;
        offset   = '0;
        next_rc  = rc;
        halt_hit = 1'b0;
        cnt      = '0;
        live     = ((state == IDLE) || (state == RUN)) && !contig_err;
        for (int i = 0; i < NUM_PORTS; i++) begin
            offset[i] = cnt;
            if (live && lanes[i].valid && !halt_hit) begin
                accept[i] = 1'b1;
                cnt       = cnt + 1'b1;
                if (lanes[i].pc_rdata == lanes[i].pc_wdata) next_rc = next_rc + 1'b1;
                else                                        next_rc = '0;
                if (next_rc == RC_W'(HALT_REPEAT)) halt_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvfi_commit_tracker.sv
// rtl/rvfi_commit_tracker.sv - multi-lane retirement order counter with halt, watchdog and contiguity checks
module rvfi_commit_tracker
    import rvfi_commit_tracker_pkg::*;
#(
    parameter int NUM_PORTS   = NUM_PORTS_DEF,
    parameter int XLEN        = XLEN_DEF,
    parameter int ORDER_W     = ORDER_W_DEF,
    parameter int HALT_REPEAT = HALT_REPEAT_DEF,
    parameter int WDOG_W      = WDOG_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           commit_valid,
    input  logic [NUM_PORTS*XLEN-1:0]      commit_pc_rdata,
    input  logic [NUM_PORTS*XLEN-1:0]      commit_pc_wdata,
    output logic [NUM_PORTS-1:0]           commit_accept,
    output logic [NUM_PORTS*ORDER_W-1:0]   order,
    output logic [ORDER_W-1:0]             commit_count,
    output logic                           halt,
    output logic                           timeout,
    output logic                           error
);

    localparam int RC_W = $clog2(HALT_REPEAT + 1);

    tracker_state_e state_q, state_d;
    logic [ORDER_W-1:0] count_q, count_d;
    logic [RC_W-1:0]    rc_q, rc_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;

    lane_t [NUM_PORTS-1:0]            lanes;
    logic  [NUM_PORTS-1:0]            scan_accept;
    logic  [NUM_PORTS-1:0][OFF_W-1:0] scan_offset;
    logic  [RC_W-1:0]                 scan_rc;
    logic                             halt_hit;
    logic                             contig_err;
    logic  [OFF_W-1:0]                n_acc;

    always_comb begin
        lanes = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            lanes[i].valid    = commit_valid[i];
            lanes[i].pc_rdata = PC_MAX_W'(commit_pc_rdata[i*XLEN +: XLEN]);
            lanes[i].pc_wdata = PC_MAX_W'(commit_pc_wdata[i*XLEN +: XLEN]);
        end
    end

    commit_lane_scan #(
        .NUM_PORTS  (NUM_PORTS),
        .HALT_REPEAT(HALT_REPEAT),
        .RC_W       (RC_W)
    ) u_scan (
        .lanes      (lanes),
        .rc         (rc_q),
        .state      (state_q),
        .accept     (scan_accept),
        .offset     (scan_offset),
        .next_rc    (scan_rc),
        .halt_hit   (halt_hit),
        .contig_err (contig_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rc_q    <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rc_q    <= rc_d;
            wdog_q  <= wdog_d;
        end
    end

    // Watchdog expiry is judged on the incremented value, so a commit in that cycle wins.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rc_d    = rc_q;
        wdog_d  = wdog_q;
        n_acc   = '0;
        for (int i = 0; i < NUM_PORTS; i++) n_acc = n_acc + OFF_W'(scan_accept[i]);
        if ((state_q == IDLE) || (state_q == RUN)) begin
            count_d = count_q + ORDER_W'(n_acc);
            rc_d    = scan_rc;
            wdog_d  = (|scan_accept) ? '0 : wdog_q + 1'b1;
            if (contig_err)         state_d = ERROR;
            else if (halt_hit)      state_d = HALTED;
            else if (|scan_accept)  state_d = RUN;
            else if (&wdog_d)       state_d = TIMEOUT;
        end
    end

    always_comb begin
        commit_accept = scan_accept;
        commit_count  = count_q;
        halt          = (state_q == HALTED);
        timeout       = (state_q == TIMEOUT);
        error         = (state_q == ERROR);
        order         = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            order[i*ORDER_W +: ORDER_W] = count_q + ORDER_W'(scan_offset[i]);
    end

endmodule
